// File: rtl/aes_cipher_hs_if.sv
// ---------------------------------------------------------------------------
// aes_cipher_hs_if
// Purpose : bundle of the block-cipher handshake signals between a producer
//           (plaintext/key source and ciphertext sink) and aes_cipher_hs.
// Signals : in_valid/in_ready  input block handshake (KEY, TextIn)
//           out_valid/out_ready output block handshake (TextOut)
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready
// are both high. The cipher samples KEY/TextIn only on that edge. TextOut is
// held stable with out_valid high until an edge with out_ready high; ready
// asserted while valid is low has no effect.
// Modports: master = block source/sink, slave = cipher core.
// ---------------------------------------------------------------------------
interface aes_cipher_hs_if #(
  parameter int KEY_BITS = 128
) ();
  logic                in_valid;
  logic                in_ready;
  logic [KEY_BITS-1:0] KEY;
  logic [127:0]        TextIn;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        TextOut;

  modport master (
    output in_valid, KEY, TextIn, out_ready,
    input  in_ready, out_valid, TextOut
  );

  modport slave (
    input  in_valid, KEY, TextIn, out_ready,
    output in_ready, out_valid, TextOut
  );
endinterface

// File: rtl/aes_cipher_hs.sv
// ---------------------------------------------------------------------------
// aes_cipher_hs
// Purpose : iterative AES-128/256 encryption, one round per clock, with the
//           key schedule expanded on the fly (no round-key storage).
// Ports   : CLK          rising-edge clock
//           Rst_n        synchronous active-low reset
//           bus          aes_cipher_hs_if slave (KEY/TextIn in, TextOut out)
//           o_fsm_state  debug view of the control FSM (0 IDLE, 1 RUN, 2 DONE)
// Byte order: [127:120] is byte 0; AES state byte index = 4*column + row.
// ---------------------------------------------------------------------------

// S-box computed as GF(2^8) inverse (x^254) followed by the affine transform.
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  always_comb begin
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = i_a;
    inv = 8'h01;
    // product of x^2, x^4 ... x^128 = x^254 = x^-1 (and 0 maps to 0)
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    o_s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_cipher_hs #(
  parameter int KEY_BITS = 128
) (
  input  logic                  CLK,
  input  logic                  Rst_n,
  aes_cipher_hs_if.slave        bus,
  output logic [1:0]            o_fsm_state
);
  localparam int         KW = KEY_BITS / 32;
  localparam logic [3:0] NR = (KW == 8) ? 4'd14 : 4'd10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} fsm_t;

  fsm_t                r_fsm, w_fsm_nxt;
  logic [127:0]        r_blk;
  logic [KEY_BITS-1:0] r_kwin;      // sliding window of Nk key-schedule words
  logic [7:0]          r_rcon;
  logic [3:0]          r_rnd;
  logic [127:0]        r_text_out;
  logic                r_out_valid;

  logic                w_accept;
  logic                w_last;
  logic [7:0]          w_sb [16];
  logic [127:0]        w_round_out;
  logic [127:0]        w_rk;
  logic [127:0]        w_new;
  logic [KEY_BITS-1:0] w_kwin_nxt;
  logic                w_rcon_type;
  logic [31:0]         w_tw, w_sw_in, w_sw_out, w_temp;
  logic [127:0]        w_top;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_cipher_hs: KEY_BITS must be 128 or 256");
  end

  assign w_accept = bus.in_valid && (r_fsm == S_IDLE);
  assign w_last   = (r_fsm == S_RUN) && (r_rnd == NR);

  // ---------------- key schedule step ----------------
  // The top four window words are w[i-Nk..i-Nk+3]; the bottom word is w[i-1].
  assign w_top = r_kwin[KEY_BITS-1 -: 128];
  assign w_tw  = r_kwin[31:0];
  // AES-256 alternates Rcon-type and SubWord-only steps, Rcon-type on odd rounds.
  assign w_rcon_type = (KW == 4) || r_rnd[0];
  assign w_sw_in     = w_rcon_type ? {w_tw[23:0], w_tw[31:24]} : w_tw;

  for (genvar g = 0; g < 4; g++) begin : g_ksb
    aes_sbox u_ksb (.i_a(w_sw_in[31-8*g -: 8]), .o_s(w_sw_out[31-8*g -: 8]));
  end

  assign w_temp = w_sw_out ^ (w_rcon_type ? {r_rcon, 24'h0} : 32'h0);
  always_comb begin
    w_new[127:96] = w_top[127:96] ^ w_temp;
    w_new[95:64]  = w_top[95:64]  ^ w_new[127:96];
    w_new[63:32]  = w_top[63:32]  ^ w_new[95:64];
    w_new[31:0]   = w_top[31:0]   ^ w_new[63:32];
  end

  if (KW == 8) begin : g_k256
    // window holds round keys rnd-1 and rnd; the new words belong to rnd+1
    assign w_rk       = r_kwin[127:0];
    assign w_kwin_nxt = {r_kwin[127:0], w_new};
  end else begin : g_k128
    assign w_rk       = w_new;
    assign w_kwin_nxt = w_new;
  end

  // ---------------- round datapath ----------------
  for (genvar g = 0; g < 16; g++) begin : g_sb
    aes_sbox u_sb (.i_a(r_blk[127-8*g -: 8]), .o_s(w_sb[g]));
  end

  always_comb begin
    logic [7:0] sr [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] shifted, mixed;
    shifted = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[c*4+r] = w_sb[((c + r) % 4) * 4 + r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[c*4];
      a1 = sr[c*4+1];
      a2 = sr[c*4+2];
      a3 = sr[c*4+3];
      shifted[127-32*c -: 32] = {a0, a1, a2, a3};
      mixed[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    // final round skips MixColumns
    w_round_out = (w_last ? shifted : mixed) ^ w_rk;
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge CLK) begin
    if (!Rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (bus.in_valid)  w_fsm_nxt = S_RUN;
      S_RUN:   if (r_rnd == NR)   w_fsm_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge CLK) begin
    if (!Rst_n) begin
      r_blk       <= '0;
      r_kwin      <= '0;
      r_rcon      <= 8'h01;
      r_rnd       <= 4'd0;
      r_text_out  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_blk  <= bus.TextIn ^ bus.KEY[KEY_BITS-1 -: 128];
      r_kwin <= bus.KEY;
      r_rcon <= 8'h01;
      r_rnd  <= 4'd1;
    end else if (r_fsm == S_RUN) begin
      r_blk  <= w_round_out;
      r_kwin <= w_kwin_nxt;
      if (w_rcon_type) r_rcon <= xtime(r_rcon);
      if (w_last) begin
        r_text_out  <= w_round_out;
        r_out_valid <= 1'b1;
        r_rnd       <= 4'd0;
      end else begin
        r_rnd <= r_rnd + 4'd1;
      end
    end else if (r_fsm == S_DONE && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = (r_fsm == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.TextOut   = r_text_out;
  assign o_fsm_state   = r_fsm;
endmodule

// File: tb/tb_aes_cipher_hs.sv
// ---------------------------------------------------------------------------
// tb_aes_cipher_hs
// Purpose : directed bench for aes_cipher_hs with one AES-128 and one AES-256
//           instance. Inputs change and outputs are sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_aes_cipher_hs;
  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KCMAC = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] LCMAC = 128'h7df76b0c1ab899b33e42f047b91b546f;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic Rst_n;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  aes_cipher_hs_if #(.KEY_BITS(128)) ifa ();
  aes_cipher_hs_if #(.KEY_BITS(256)) ifb ();
  logic [1:0] st_a, st_b;

  aes_cipher_hs #(.KEY_BITS(128)) u_a (.CLK(CLK), .Rst_n(Rst_n), .bus(ifa.slave), .o_fsm_state(st_a));
  aes_cipher_hs #(.KEY_BITS(256)) u_b (.CLK(CLK), .Rst_n(Rst_n), .bus(ifb.slave), .o_fsm_state(st_b));

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  // ---------------- driver tasks (AES-128 instance) ----------------
  task automatic send_a(input logic [127:0] key, input logic [127:0] txt, input logic [127:0] exp);
    ifa.KEY      = key;
    ifa.TextIn   = txt;
    ifa.in_valid = 1'b1;
    chk("accept_in_ready", {255'd0, ifa.in_ready}, 256'd1);
    exp_q.push_back(exp);
    @(negedge CLK);
    ifa.in_valid = 1'b0;
    ifa.KEY      = rnd128();
    ifa.TextIn   = rnd128();
  endtask

  task automatic wait_a(input int exp_lat, input string tag);
    int lat;
    logic [127:0] e;
    lat = 0;
    while (ifa.out_valid !== 1'b1 && lat < 40) begin
      chk({tag, "_run_in_ready"}, {255'd0, ifa.in_ready}, 256'd0);
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_latency"}, 256'(lat), 256'(exp_lat));
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL %s_queue: observed empty expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_text"}, {128'd0, ifa.TextOut}, {128'd0, e});
    end
  endtask

  task automatic release_a(input string tag);
    ifa.out_ready = 1'b1;
    chk({tag, "_done_in_ready"}, {255'd0, ifa.in_ready}, 256'd0);
    chk({tag, "_done_valid"}, {255'd0, ifa.out_valid}, 256'd1);
    @(negedge CLK);
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b0;
    chk({tag, "_rel_valid"}, {255'd0, ifa.out_valid}, 256'd0);
    chk({tag, "_rel_in_ready"}, {255'd0, ifa.in_ready}, 256'd1);
    chk({tag, "_rel_state"}, {254'd0, st_a}, 256'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    logic [127:0] held;
    logic [127:0] e;
    Rst_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.out_ready = 1'b0; ifa.KEY = '0; ifa.TextIn = '0;
    ifb.in_valid = 1'b0; ifb.out_ready = 1'b0; ifb.KEY = '0; ifb.TextIn = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", {255'd0, ifa.in_ready}, 256'd1);
    chk("rst_out_valid", {255'd0, ifa.out_valid}, 256'd0);
    chk("rst_text", {128'd0, ifa.TextOut}, 256'd0);
    chk("rst_state", {254'd0, st_a}, 256'd0);
    chk("rst_b_in_ready", {255'd0, ifb.in_ready}, 256'd1);
    Rst_n = 1'b1;
    @(negedge CLK);

    // T1: FIPS-197 C.1
    send_a(K128, PT, CT128);
    wait_a(10, "t1");
    release_a("t1");

    // T3: CMAC subkey L
    send_a(KCMAC, 128'd0, LCMAC);
    wait_a(10, "t3");
    release_a("t3");

    // T2: FIPS-197 C.3 on the AES-256 instance
    ifb.KEY = K256; ifb.TextIn = PT; ifb.in_valid = 1'b1;
    chk("t2_accept_in_ready", {255'd0, ifb.in_ready}, 256'd1);
    exp_q.push_back(CT256);
    @(negedge CLK);
    ifb.in_valid = 1'b0; ifb.KEY = {rnd128(), rnd128()}; ifb.TextIn = rnd128();
    lat = 0;
    while (ifb.out_valid !== 1'b1 && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    chk("t2_latency", 256'(lat), 256'd14);
    e = exp_q.pop_front();
    chk("t2_text", {128'd0, ifb.TextOut}, {128'd0, e});
    ifb.out_ready = 1'b1;
    @(negedge CLK);
    ifb.out_ready = 1'b0;
    chk("t2_rel_valid", {255'd0, ifb.out_valid}, 256'd0);
    chk("t2_rel_in_ready", {255'd0, ifb.in_ready}, 256'd1);

    // T4: back-pressure, with a competing in_valid held during DONE
    send_a(K128, PT, CT128);
    wait_a(10, "t4");
    held = ifa.TextOut;
    ifa.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("t4_hold_valid", {255'd0, ifa.out_valid}, 256'd1);
      chk("t4_hold_text", {128'd0, ifa.TextOut}, {128'd0, CT128});
      chk("t4_hold_in_ready", {255'd0, ifa.in_ready}, 256'd0);
    end
    release_a("t4");
    @(negedge CLK);
    chk("t4_no_accept", {254'd0, st_a}, 256'd0);

    // T5: operand isolation during RUN
    send_a(K128, PT, CT128);
    for (int i = 0; i < 3; i++) begin
      ifa.in_valid = 1'b1;
      ifa.KEY      = rnd128();
      ifa.TextIn   = rnd128();
      @(negedge CLK);
      ifa.in_valid = 1'b0;
    end
    wait_a(7, "t5");
    release_a("t5");
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t5_idle_valid", {255'd0, ifa.out_valid}, 256'd0);
      chk("t5_idle_state", {254'd0, st_a}, 256'd0);
    end

    // T6: reset after round 5, then a clean T1
    send_a(K128, PT, CT128);
    for (int i = 0; i < 5; i++) @(negedge CLK);
    chk("t6_mid_state", {254'd0, st_a}, 256'd1);
    Rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("t6_rst_valid", {255'd0, ifa.out_valid}, 256'd0);
      chk("t6_rst_text", {128'd0, ifa.TextOut}, 256'd0);
      chk("t6_rst_state", {254'd0, st_a}, 256'd0);
    end
    Rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      chk("t6_no_partial", {255'd0, ifa.out_valid}, 256'd0);
    end
    send_a(K128, PT, CT128);
    wait_a(10, "t6");
    release_a("t6");

    chk("final_queue_empty", 256'(exp_q.size()), 256'd0);
    chk("t4_held_text", {128'd0, held}, {128'd0, CT128});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
